// File: rtl/bits_stream_unpacker_pkg.sv
// Shared constants and helpers for the bit-stream unpacker: default sizes,
// derived pointer/level widths and the bit-order reversal used for MSB-first output.
package bits_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_MAX_LEN = 15;

  // Widest field the reversal helper handles; MAX_LEN must not exceed this.
  localparam int REV_W = 64;

  function automatic int level_width(input int depth, input int in_w);
    return $clog2(depth * in_w + 1);
  endfunction

  function automatic int ptr_width(input int depth, input int in_w);
    return $clog2(depth * in_w);
  endfunction

  function automatic logic [REV_W-1:0] reverse_bits(input logic [REV_W-1:0] v);
    logic [REV_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_W; i++) begin
      r[i] = v[REV_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bits_stream_unpacker_if.sv
// Push/request handshake bundle between a word producer, the unpacker and
// a field consumer; master drives words and requests, slave is the unpacker.
interface bits_stream_unpacker_if
  import bits_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               pushin;
  logic [IN_W-1:0]    datain;
  logic               fullout;
  logic               reqin;
  logic [LEN_W-1:0]   reqlen;
  logic               reqready;
  logic               pushout;
  logic [LEN_W-1:0]   lenout;
  logic [MAX_LEN-1:0] dataout;

  modport master (
    output pushin, datain, reqin, reqlen,
    input  fullout, reqready, pushout, lenout, dataout
  );

  modport slave (
    input  pushin, datain, reqin, reqlen,
    output fullout, reqready, pushout, lenout, dataout
  );

endinterface

// File: rtl/bits_stream_unpacker_window_extract.sv
// Combinational field extractor: pulls up to MAX_LEN bits starting at bit
// pointer rp out of the circular word buffer, zeroing bits above len.
module bits_window_extract
  import bits_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int PTR_W   = ptr_width(DEPTH, IN_W)
) (
  input  logic [IN_W-1:0]    mem [DEPTH],
  input  logic [PTR_W-1:0]   rp,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] field
);

  localparam int OFF_W = $clog2(IN_W);
  localparam int WP_W  = $clog2(DEPTH);

  logic [WP_W-1:0]   word_idx;
  logic [WP_W-1:0]   next_idx;
  logic [OFF_W-1:0]  bit_off;
  logic [2*IN_W-1:0] pair;

  // MAX_LEN < IN_W, so a field never touches more than two adjacent words;
  // next_idx wraps naturally, which makes fields across the buffer end contiguous.
  always_comb begin
    word_idx = rp[PTR_W-1:OFF_W];
    bit_off  = rp[OFF_W-1:0];
    next_idx = word_idx + 1'b1;
    pair     = {mem[next_idx], mem[word_idx]};
    field    = MAX_LEN'((pair >> bit_off) & ~({(2*IN_W){1'b1}} << len));
  end

endmodule

// File: rtl/bits_stream_unpacker.sv
// Word-in, variable-length-field-out bit buffer with occupancy tracking,
// full/ready handshakes, sticky overflow and a two-edge field delivery pipeline.
module bits_stream_unpacker
  import bits_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int LEN_W     = $clog2(MAX_LEN + 1),
  parameter int MSB_FIRST = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  bits_stream_unpacker_if.slave              bus,
  output logic [level_width(DEPTH, IN_W)-1:0] level,
  output logic                               ovf
);

  localparam int LVL_W = level_width(DEPTH, IN_W);
  localparam int PTR_W = ptr_width(DEPTH, IN_W);
  localparam int WP_W  = $clog2(DEPTH);
  localparam int TOTAL = DEPTH * IN_W;

  logic [IN_W-1:0]    mem_q [DEPTH];
  logic [IN_W-1:0]    mem_d [DEPTH];
  logic [WP_W-1:0]    wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               ovf_q, ovf_d;

  logic               x_valid_q, x_valid_d;
  logic [LEN_W-1:0]   x_len_q, x_len_d;
  logic [MAX_LEN-1:0] x_field_q, x_field_d;

  logic               pushout_q, pushout_d;
  logic [LEN_W-1:0]   lenout_q, lenout_d;
  logic [MAX_LEN-1:0] dataout_q, dataout_d;

  logic [LEN_W-1:0]   len_sat;
  logic               reqready_c;
  logic               push_acc;
  logic               req_acc;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] ordered;

  // Oversized requests saturate; readiness uses the pre-push level only.
  always_comb begin
    len_sat = bus.reqlen;
    if (bus.reqlen > LEN_W'(MAX_LEN)) begin
      len_sat = LEN_W'(MAX_LEN);
    end
    reqready_c = level_q >= LVL_W'(len_sat);
    push_acc   = bus.pushin && !full_q;
    req_acc    = bus.reqin && reqready_c;
  end

  bits_window_extract #(
    .IN_W    (IN_W),
    .DEPTH   (DEPTH),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .PTR_W   (PTR_W)
  ) u_extract (
    .mem   (mem_q),
    .rp    (rp_q),
    .len   (len_sat),
    .field (window)
  );

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    ovf_d   = ovf_q | (bus.pushin & full_q);
    if (push_acc) begin
      mem_d[wp_q] = bus.datain;
      wp_d        = wp_q + 1'b1;
    end
    if (req_acc) begin
      rp_d = rp_q + PTR_W'(len_sat);
    end
    level_d = level_q + (push_acc ? LVL_W'(IN_W) : '0) - (req_acc ? LVL_W'(len_sat) : '0);
    full_d  = level_d > LVL_W'(TOTAL - IN_W);
  end

  // Stage one captures the raw field; stage two applies bit order and
  // presents it, so pushout rises two edges after acceptance.
  always_comb begin
    x_valid_d = req_acc;
    x_len_d   = req_acc ? len_sat : x_len_q;
    x_field_d = req_acc ? window  : x_field_q;

    if (MSB_FIRST != 0) begin
      ordered = MAX_LEN'(reverse_bits(REV_W'(x_field_q)) >> (REV_W - int'(x_len_q)));
    end else begin
      ordered = x_field_q;
    end

    pushout_d = x_valid_q;
    lenout_d  = x_valid_q ? x_len_q : lenout_q;
    dataout_d = x_valid_q ? ordered : dataout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      x_valid_q <= 1'b0;
      x_len_q   <= '0;
      x_field_q <= '0;
      pushout_q <= 1'b0;
      lenout_q  <= '0;
      dataout_q <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      level_q   <= level_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      x_valid_q <= x_valid_d;
      x_len_q   <= x_len_d;
      x_field_q <= x_field_d;
      pushout_q <= pushout_d;
      lenout_q  <= lenout_d;
      dataout_q <= dataout_d;
    end
  end

  // Buffer contents are meaningless after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.fullout  = full_q;
  assign bus.reqready = reqready_c;
  assign bus.pushout  = pushout_q;
  assign bus.lenout   = lenout_q;
  assign bus.dataout  = dataout_q;
  assign level        = level_q;
  assign ovf          = ovf_q;

endmodule
